register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-port register bank. It is the successor of the single-write, two-read CPU register memory. It adds:
- configurable data width, depth and read-port count
- a second write port with fixed priority
- an optional hardwired zero register
- a sequenced clear engine that zeroes one entry per cycle after reset and reports readiness.

It sits in the decode stage and feeds ALU operands. Write-back and load-return paths drive its two write ports.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries.
- NREAD, 2, number of independent combinational read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; starts the clear sequence.
- ready  out  1  high when the clear sequence is complete and the bank accepts writes.
- regWrite0  in  1  write enable, port 0 (write-back).
- writeRegister0  in  ADDR_W  write index, port 0.
- writeData0  in  DATA_W  write data, port 0.
- regWrite1  in  1  write enable, port 1 (load return; has priority).
- writeRegister1  in  ADDR_W  write index, port 1.
- writeData1  in  DATA_W  write data, port 1.
- readRegister  in  NREAD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- readData  out  NREAD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high, named `reset`.
- Clear FSM has two states, CLEAR and RUN.
- Cycle with reset=1:
  - state <= CLEAR, clr_ptr <= 0, ready <= 0.
  - Storage is not touched in this cycle.
- CLEAR, reset=0:
  - each cycle write 0 to entry clr_ptr, then clr_ptr <= clr_ptr+1.
  - When clr_ptr == DEPTH-1, that entry is cleared and state <= RUN, ready <= 1.
  - ready therefore rises exactly DEPTH clock edges after the first reset-low edge.
- Reset asserted during CLEAR or RUN restarts the sequence from clr_ptr=0 (ready drops at that edge).
- While ready=0:
  - all regWrite inputs are ignored (no storage update, no bypass).
  - every readData port returns 0.
- RUN write rules (rising edge):
  - port p writes entry writeRegisterp when regWritep=1.
  - If ZERO_REG=1, writes to index 0 are dropped.
  - Both ports enabled with the same index: port 1 value is stored, port 0 is discarded.
  - Different indices: both are stored in the same cycle.
- Read rules (combinational, zero latency), evaluated independently per read port k, first match wins:
  1. ready=0 -> 0.
  2. ZERO_REG=1 and index==0 -> 0.
  3. regWrite1=1 and writeRegister1==index -> writeData1 (bypass).
  4. regWrite0=1 and writeRegister0==index -> writeData0 (bypass).
  5. otherwise -> stored entry.
- Bypass lets a value written in cycle N be seen by a read in the same cycle N; the stored value is visible from cycle N+1.
- No write is acknowledged or stalled. Callers gate write-back on ready.
- Widths: no arithmetic on data. clr_ptr is ADDR_W bits and is not incremented past DEPTH-1.

Test Plan:
- Clear sequence: preload by writing 0xDEADBEEF to r5 in RUN, pulse reset 1 cycle, then hold reset low -> ready=0 for exactly 32 edges (DEPTH=32), then 1; readData for r5 = 0 throughout and after ready.
- Basic write/read: write 0x12345678 to r3 via port 0, then read r3 on ports 0 and 1 next cycle -> both 0x12345678.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0 on both ports -> r0 reads 0 on the same cycle and the next. ZERO_REG=0 -> r0 reads 0xFFFFFFFF next cycle.
- Dual write, same index: port0 writes 0xAAAA0000 and port1 writes 0x0000BBBB to r7 in the same cycle -> bypass read is 0x0000BBBB, stored value next cycle is 0x0000BBBB. Different indices r8/r9 -> both stored.
- Bypass: read r10 while port0 writes 0x55 to r10 -> readData = 0x55 in the same cycle. Stale stored value 0 is never visible.
- Reset mid-clear: assert reset at clear cycle 10 -> ready stays 0, then rises 32 edges after reset deasserts. Writes attempted during clear are ignored (read 0 after ready).

Source files
------------

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - parametrised multi-port register bank with sequenced clear
//
// Purpose:
//   Register bank for the decode stage. It has two write ports: port 0 carries write-back
//   and port 1 carries load return, and port 1 wins when both ports target the same entry.
//   It has NREAD combinational read ports with same-cycle write bypass. An optional
//   hardwired zero register is selected by ZERO_REG. After reset a clear engine zeroes one
//   entry per cycle, and `ready` rises once every entry has been cleared.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset; restarts the clear sequence
//   ready          out  clear sequence complete; bank accepts writes, reads are live
//   regWrite0      in   write enable, port 0
//   writeRegister0 in   write index, port 0
//   writeData0     in   write data, port 0
//   regWrite1      in   write enable, port 1 (priority)
//   writeRegister1 in   write index, port 1
//   writeData1     in   write data, port 1
//   readRegister   in   packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   readData       out  packed read data, port k at [k*DATA_W +: DATA_W]

module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    ready,
  input  logic                    regWrite0,
  input  logic [ADDR_W-1:0]       writeRegister0,
  input  logic [DATA_W-1:0]       writeData0,
  input  logic                    regWrite1,
  input  logic [ADDR_W-1:0]       writeRegister1,
  input  logic [DATA_W-1:0]       writeData1,
  input  logic [NREAD*ADDR_W-1:0] readRegister,
  output logic [NREAD*DATA_W-1:0] readData
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               zero_reg_en;
  logic               we0, we1;

  assign zero_reg_en = (ZERO_REG != 0);
  assign ready       = ready_q;

  // Index-0 writes are dropped here, so entry 0 stays at its cleared value when it is hardwired.
  assign we0 = ready_q && !reset && regWrite0 &&
               !(zero_reg_en && (writeRegister0 == '0));
  assign we1 = ready_q && !reset && regWrite1 &&
               !(zero_reg_en && (writeRegister1 == '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_ptr_q == LAST_IDX) begin
          // Pointer holds at the last index rather than wrapping.
          state_d = S_RUN;
          ready_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      S_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // Storage has no reset of its own. The cycle in which reset is asserted leaves it untouched.
  // Port 1 is assigned after port 0, so port 1's value is the one kept when both ports hit the
  // same entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        if (we0) mem_q[writeRegister0] <= writeData0;
        if (we1) mem_q[writeRegister1] <= writeData1;
      end
    end
  end

  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    readData = '0;
    rd_idx   = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_idx = readRegister[k*ADDR_W +: ADDR_W];
      if (!ready_q) begin
        readData[k*DATA_W +: DATA_W] = '0;
      end else if (zero_reg_en && (rd_idx == '0)) begin
        readData[k*DATA_W +: DATA_W] = '0;
      end else if (regWrite1 && (writeRegister1 == rd_idx)) begin
        readData[k*DATA_W +: DATA_W] = writeData1;
      end else if (regWrite0 && (writeRegister0 == rd_idx)) begin
        readData[k*DATA_W +: DATA_W] = writeData0;
      end else begin
        readData[k*DATA_W +: DATA_W] = mem_q[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed self-checking bench for register_file_mp
module tb_register_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    regWrite0, regWrite1;
  logic [ADDR_W-1:0]       writeRegister0, writeRegister1;
  logic [DATA_W-1:0]       writeData0, writeData1;
  logic [NREAD*ADDR_W-1:0] readRegister;
  logic                    ready_z, ready_nz;
  logic [NREAD*DATA_W-1:0] rd_z, rd_nz;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1)) u_dut (
    .clock(clock), .reset(reset), .ready(ready_z),
    .regWrite0(regWrite0), .writeRegister0(writeRegister0), .writeData0(writeData0),
    .regWrite1(regWrite1), .writeRegister1(writeRegister1), .writeData1(writeData1),
    .readRegister(readRegister), .readData(rd_z)
  );

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(0)) u_dut_nz (
    .clock(clock), .reset(reset), .ready(ready_nz),
    .regWrite0(regWrite0), .writeRegister0(writeRegister0), .writeData0(writeData0),
    .regWrite1(regWrite1), .writeRegister1(writeRegister1), .writeData1(writeData1),
    .readRegister(readRegister), .readData(rd_nz)
  );

  task automatic idle();
    regWrite0 = 1'b0; writeRegister0 = '0; writeData0 = '0;
    regWrite1 = 1'b0; writeRegister1 = '0; writeData1 = '0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    readRegister = {a1, a0};
  endtask

  // Called at a negedge just after reset drops; counts edges until ready, bounded.
  task automatic wait_ready(output int edges, output bit bad_read, output bit mism);
    edges = 0; bad_read = 1'b0; mism = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      edges++;
      if (ready_z !== ready_nz) mism = 1'b1;
      if (ready_z === 1'b1) break;
      if (rd_z !== '0 || rd_nz !== '0) bad_read = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    int edges; bit bad; bit mm;
    idle(); set_rd(5, 3); reset = 1'b1;
    @(negedge clock); @(negedge clock);
    checks++;
    if (ready_z !== 1'b0 || ready_nz !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b/%b want 0/0", ready_z, ready_nz);
    end
    checks++;
    if (rd_z !== '0) begin
      errors++; $display("FAIL reset_read got %h want 0", rd_z);
    end
    reset = 1'b0;
    wait_ready(edges, bad, mm);
    checks++;
    if (edges !== 32) begin
      errors++; $display("FAIL reset_ready_edges got %0d want 32", edges);
    end
    checks++;
    if (bad !== 1'b0 || mm !== 1'b0) begin
      errors++; $display("FAIL reset_clear_reads got bad=%b mism=%b want 0/0", bad, mm);
    end
  endtask

  task automatic test_basic_write();
    @(negedge clock);
    regWrite0 = 1'b1; writeRegister0 = 5'd3; writeData0 = 32'h12345678;
    set_rd(3, 3);
    @(negedge clock); idle(); #1;
    checks++;
    if (rd_z !== {2{32'h12345678}} || rd_nz !== {2{32'h12345678}}) begin
      errors++; $display("FAIL basic_write got %h/%h want %h", rd_z, rd_nz, {2{32'h12345678}});
    end
  endtask

  task automatic test_clear_sequence();
    int edges; bit bad; bit mm;
    @(negedge clock);
    regWrite0 = 1'b1; writeRegister0 = 5'd5; writeData0 = 32'hDEADBEEF;
    set_rd(5, 5);
    @(negedge clock); idle(); #1;
    checks++;
    if (rd_z !== {2{32'hDEADBEEF}}) begin
      errors++; $display("FAIL preload_r5 got %h want %h", rd_z, {2{32'hDEADBEEF}});
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ready_z !== 1'b0 || rd_z !== '0) begin
      errors++; $display("FAIL clear_reset_edge got ready=%b rd=%h want 0/0", ready_z, rd_z);
    end
    reset = 1'b0;
    wait_ready(edges, bad, mm);
    checks++;
    if (edges !== 32 || bad !== 1'b0 || mm !== 1'b0) begin
      errors++; $display("FAIL clear_seq got edges=%0d bad=%b mism=%b want 32/0/0", edges, bad, mm);
    end
    #1;
    checks++;
    if (rd_z !== '0 || rd_nz !== '0) begin
      errors++; $display("FAIL clear_r5_after got %h/%h want 0", rd_z, rd_nz);
    end
    set_rd(3, 5); #1;
    checks++;
    if (rd_z !== '0) begin
      errors++; $display("FAIL clear_r3_after got %h want 0", rd_z);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    regWrite0 = 1'b1; writeRegister0 = 5'd0; writeData0 = 32'hFFFFFFFF;
    regWrite1 = 1'b1; writeRegister1 = 5'd0; writeData1 = 32'hFFFFFFFF;
    set_rd(0, 0); #1;
    checks++;
    if (rd_z !== '0) begin
      errors++; $display("FAIL zero_reg_same got %h want 0", rd_z);
    end
    checks++;
    if (rd_nz !== {2{32'hFFFFFFFF}}) begin
      errors++; $display("FAIL nozero_bypass got %h want all ones", rd_nz);
    end
    @(negedge clock); idle(); #1;
    checks++;
    if (rd_z !== '0) begin
      errors++; $display("FAIL zero_reg_next got %h want 0", rd_z);
    end
    checks++;
    if (rd_nz !== {2{32'hFFFFFFFF}}) begin
      errors++; $display("FAIL nozero_stored got %h want all ones", rd_nz);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clock);
    regWrite0 = 1'b1; writeRegister0 = 5'd7; writeData0 = 32'hAAAA0000;
    regWrite1 = 1'b1; writeRegister1 = 5'd7; writeData1 = 32'h0000BBBB;
    set_rd(7, 7); #1;
    checks++;
    if (rd_z !== {2{32'h0000BBBB}}) begin
      errors++; $display("FAIL dual_same_bypass got %h want %h", rd_z, {2{32'h0000BBBB}});
    end
    @(negedge clock); idle(); #1;
    checks++;
    if (rd_z !== {2{32'h0000BBBB}}) begin
      errors++; $display("FAIL dual_same_stored got %h want %h", rd_z, {2{32'h0000BBBB}});
    end
    @(negedge clock);
    regWrite0 = 1'b1; writeRegister0 = 5'd8; writeData0 = 32'h11112222;
    regWrite1 = 1'b1; writeRegister1 = 5'd9; writeData1 = 32'h33334444;
    set_rd(8, 9); #1;
    checks++;
    if (rd_z !== {32'h33334444, 32'h11112222}) begin
      errors++; $display("FAIL dual_diff_bypass got %h want %h", rd_z, {32'h33334444, 32'h11112222});
    end
    @(negedge clock); idle(); #1;
    checks++;
    if (rd_z !== {32'h33334444, 32'h11112222}) begin
      errors++; $display("FAIL dual_diff_stored got %h want %h", rd_z, {32'h33334444, 32'h11112222});
    end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    idle(); set_rd(10, 10); #1;
    checks++;
    if (rd_z !== '0) begin
      errors++; $display("FAIL bypass_pre got %h want 0", rd_z);
    end
    regWrite0 = 1'b1; writeRegister0 = 5'd10; writeData0 = 32'h55; #1;
    checks++;
    if (rd_z !== {2{32'h00000055}}) begin
      errors++; $display("FAIL bypass_same got %h want %h", rd_z, {2{32'h00000055}});
    end
    @(negedge clock); idle(); #1;
    checks++;
    if (rd_z !== {2{32'h00000055}}) begin
      errors++; $display("FAIL bypass_stored got %h want %h", rd_z, {2{32'h00000055}});
    end
  endtask

  task automatic test_reset_mid_clear();
    int edges; bit bad; bit mm;
    @(negedge clock);
    idle(); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (ready_z !== 1'b0) begin
      errors++; $display("FAIL midclear_ready got %b want 0", ready_z);
    end
    reset = 1'b0;
    regWrite0 = 1'b1; writeRegister0 = 5'd11; writeData0 = 32'h77;
    regWrite1 = 1'b1; writeRegister1 = 5'd12; writeData1 = 32'h99;
    set_rd(11, 12); #1;
    checks++;
    if (rd_z !== '0) begin
      errors++; $display("FAIL midclear_no_bypass got %h want 0", rd_z);
    end
    wait_ready(edges, bad, mm);
    checks++;
    if (edges !== 32 || bad !== 1'b0 || mm !== 1'b0) begin
      errors++; $display("FAIL midclear_seq got edges=%0d bad=%b mism=%b want 32/0/0", edges, bad, mm);
    end
    idle(); #1;
    checks++;
    if (rd_z !== '0 || rd_nz !== '0) begin
      errors++; $display("FAIL midclear_writes_ignored got %h/%h want 0", rd_z, rd_nz);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    readRegister = '0;
    test_reset();
    test_basic_write();
    test_clear_sequence();
    test_zero_reg();
    test_dual_write();
    test_bypass();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
